heapsort_stream_ctrl: RTL

HEAPSORT_STREAM_CTRL -- requirements
Module: heapsort_stream_ctrl

---
 rtl/heapsort_stream_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/heapsort_stream_ctrl.sv
// rtl/heapsort_stream_ctrl.sv - streaming job controller wrapped around an external fixed-latency sort core
// Loads up to N elements, pads the remainder with all-ones, waits LAT cycles, then drains count results.
module heapsort_stream_ctrl #(
    parameter int N   = 23,
    parameter int W   = 7,
    parameter int LAT = 4
) (
    input  logic           system1000,
    input  logic           system1000_rstn,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [N*W-1:0] core_vec_o,
    input  logic [N*W-1:0] core_vec_i,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    input  logic           out_ready,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  rd_idx_q, rd_idx_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [N*W-1:0] slot_q, slot_d;
    logic [N*W-1:0] cap_q, cap_d;
    logic           in_ready_q, in_ready_d;

    logic [CW-1:0]  wr_idx;
    logic           in_fire;
    logic           out_fire;
    logic           end_job;
    logic           wait_done;

    // The first element of a job always lands in slot 0, regardless of a stale count.
    assign wr_idx    = (state_q == S_IDLE) ? '0 : count_q;
    assign in_fire   = in_valid && in_ready_q;
    assign end_job   = in_fire && (in_last || (wr_idx == CW'(N - 1)));
    assign wait_done = (state_q == S_WAIT) && (wait_q == WW'(LAT - 1));

    assign out_valid  = (state_q == S_DRAIN);
    assign out_fire   = out_valid && out_ready;
    assign out_data   = out_valid ? cap_q[rd_idx_q*W +: W] : '0;
    assign out_last   = out_valid && (rd_idx_q == (count_q - CW'(1)));
    assign busy       = (state_q != S_IDLE);
    assign in_ready   = in_ready_q;
    assign core_vec_o = slot_q;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        wait_d   = wait_q;
        slot_d   = slot_q;
        cap_d    = cap_q;

        // Padding is written on the same edge as the final element so WAIT sees a frozen vector.
        for (int k = 0; k < N; k++) begin
            if (in_fire && (CW'(k) == wr_idx)) begin
                slot_d[k*W +: W] = in_data;
            end else if (end_job && (CW'(k) > wr_idx)) begin
                slot_d[k*W +: W] = '1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    count_d = CW'(1);
                    state_d = end_job ? S_WAIT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    count_d = count_q + CW'(1);
                    if (end_job) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    wait_d   = '0;
                    cap_d    = core_vec_i;
                    rd_idx_d = '0;
                    state_d  = S_DRAIN;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (out_last) begin
                        state_d  = S_IDLE;
                        count_d  = '0;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_idx_q   <= '0;
            wait_q     <= '0;
            slot_q     <= '0;
            cap_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_idx_q   <= rd_idx_d;
            wait_q     <= wait_d;
            slot_q     <= slot_d;
            cap_q      <= cap_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule
